// File: rtl/cruzamento_pkg.sv
// cruzamento_pkg
// Shared types and constants for the intersection phase scheduler.
//   estado_t   : seven phase states, 3-bit encoding
//   VERDE/AMARELO/VERMELHO : lamp codes driven onto luz_a / luz_b
//   LADO_A/LADO_B          : values of the 1-bit "next approach" register
package cruzamento_pkg;

  typedef enum logic [2:0] {
    VERDE_A = 3'd0,
    AMAR_A  = 3'd1,
    LIMPA_A = 3'd2,
    PED     = 3'd3,
    VERDE_B = 3'd4,
    AMAR_B  = 3'd5,
    LIMPA_B = 3'd6
  } estado_t;

  localparam logic [1:0] VERDE    = 2'b00;
  localparam logic [1:0] AMARELO  = 2'b01;
  localparam logic [1:0] VERMELHO = 2'b10;

  localparam logic LADO_A = 1'b0;
  localparam logic LADO_B = 1'b1;

endpackage

// File: rtl/cruzamento_ctrl_fase_timer.sv
// fase_timer
// Elapsed-cycle counter for the current phase. Limit comparisons are done
// by the controller; this block only counts.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears cnt
//   clr   : synchronous clear, asserted on every phase transition
//   cnt   : cycles spent in the current phase (0 on the first cycle)
module fase_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  output logic [15:0] cnt
);

  // No wrap protection: every phase leaves at or before its own limit,
  // so the counter never reaches its maximum value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= 16'd0;
    else if (clr)
      cnt <= 16'd0;
    else
      cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/cruzamento_ctrl.sv
// cruzamento_ctrl
// Demand-driven phase scheduler for a two-approach crossing with a
// pedestrian walk phase. Minimum/maximum green, fixed yellow, all-red
// clearance, and a latched pedestrian request. Outputs are Moore: they
// decode from the state register and the ped_pend flop only.
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   car_a, car_b     : vehicle demand levels, sampled every cycle
//   botao            : pedestrian button level
//   luz_a, luz_b     : lamp codes for each head (00 green, 01 yellow, 10 red)
//   pedestre         : walk lamp
//   ped_pend         : pedestrian request latched and not yet served
module cruzamento_ctrl
  import cruzamento_pkg::*;
#(
  parameter logic [15:0] T_MIN   = 16'd2000,
  parameter logic [15:0] T_MAX   = 16'd10000,
  parameter logic [15:0] T_AMAR  = 16'd500,
  parameter logic [15:0] T_LIMPA = 16'd100,
  parameter logic [15:0] T_PED   = 16'd3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       car_a,
  input  logic       car_b,
  input  logic       botao,
  output logic [1:0] luz_a,
  output logic [1:0] luz_b,
  output logic       pedestre,
  output logic       ped_pend
);

  estado_t     estado;
  estado_t     prox_estado;
  logic        prox;
  logic [15:0] cnt;
  logic        troca;
  logic        entra_ped;

  assign troca     = (prox_estado != estado);
  assign entra_ped = (prox_estado == PED) && (estado != PED);

  fase_timer u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (troca),
    .cnt   (cnt)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado <= VERDE_A;
    else
      estado <= prox_estado;
  end

  // prox remembers which green follows the walk phase: the approach
  // opposite to the one whose clearance led into PED.
  // ped_pend: the clear on entry to PED has priority over a simultaneous
  // button press, and the button is ignored while walking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prox     <= LADO_B;
      ped_pend <= 1'b0;
    end else begin
      if (entra_ped)
        prox <= (estado == LIMPA_A) ? LADO_B : LADO_A;
      if (entra_ped)
        ped_pend <= 1'b0;
      else if (botao && (estado != PED))
        ped_pend <= 1'b1;
    end
  end

  // Next-state logic. Demand from the other side is looked at only on the
  // cycle a green could end; it is not remembered across cycles.
  always_comb begin
    prox_estado = estado;
    unique case (estado)
      VERDE_A: begin
        if ((cnt == T_MAX - 16'd1) ||
            ((cnt >= T_MIN - 16'd1) && (car_b || ped_pend)))
          prox_estado = AMAR_A;
      end
      AMAR_A: begin
        if (cnt == T_AMAR - 16'd1)
          prox_estado = LIMPA_A;
      end
      LIMPA_A: begin
        if (cnt == T_LIMPA - 16'd1)
          prox_estado = ped_pend ? PED : VERDE_B;
      end
      PED: begin
        if (cnt == T_PED - 16'd1)
          prox_estado = (prox == LADO_A) ? VERDE_A : VERDE_B;
      end
      VERDE_B: begin
        if ((cnt == T_MAX - 16'd1) ||
            ((cnt >= T_MIN - 16'd1) && (car_a || ped_pend)))
          prox_estado = AMAR_B;
      end
      AMAR_B: begin
        if (cnt == T_AMAR - 16'd1)
          prox_estado = LIMPA_B;
      end
      LIMPA_B: begin
        if (cnt == T_LIMPA - 16'd1)
          prox_estado = ped_pend ? PED : VERDE_A;
      end
      default: prox_estado = VERDE_A;
    endcase
  end

  // Lamp decode. Anything unexpected falls back to all-red.
  always_comb begin
    luz_a    = VERMELHO;
    luz_b    = VERMELHO;
    pedestre = 1'b0;
    unique case (estado)
      VERDE_A: luz_a = VERDE;
      AMAR_A:  luz_a = AMARELO;
      PED:     pedestre = 1'b1;
      VERDE_B: luz_b = VERDE;
      AMAR_B:  luz_b = AMARELO;
      default: ;
    endcase
  end

endmodule
